// File: rtl/ccu_pkg.sv
// ccu_pkg: dispatcher state encoding and default header geometry
package ccu_pkg;
    localparam int CFG_PW      = 128;
    localparam int CFG_NUM_MOD = 8;
    localparam int CFG_LEN_W   = 8;
    localparam int ID_W        = 4;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_FIN} state_t;
endpackage

// File: rtl/cfg_skid_buf.sv
// cfg_skid_buf: 2-entry FIFO holding popped config words ahead of the dispatcher
module cfg_skid_buf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_occ
);
    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_occ;
    // storage, pointers and occupancy; push and pop may happen in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) r_mem[r_wp] <= i_din;
            r_wp  <= r_wp ^ i_push;
            r_rp  <= r_rp ^ i_pop;
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end
    assign o_head = r_mem[r_rp];
    assign o_occ  = r_occ;
endmodule

// File: rtl/ccu_cfg_dispatch.sv
// ccu_cfg_dispatch: parses config headers from the command FIFO and streams payloads to engines.
// Optional CCU_CFG_STALL_CNT_EN adds a saturating vld&&!rdy stall counter; otherwise stall_cnt is 0.
module ccu_cfg_dispatch
    import ccu_pkg::*;
#(
    parameter int PORT_WIDTH = CFG_PW,
    parameter int NUM_MOD    = CFG_NUM_MOD,
    parameter int LEN_WIDTH  = CFG_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [PORT_WIDTH-1:0] fifo_out,
    output logic [NUM_MOD-1:0]    CCUTOP_CfgVld,
    output logic [PORT_WIDTH-1:0] CCUTOP_CfgInfo,
    input  logic [NUM_MOD-1:0]    TOPCCU_CfgRdy,
    output logic                  busy,
    output logic                  done,
    output logic                  err_id,
    output logic [31:0]           stall_cnt
);
    localparam int ID_LSB  = PORT_WIDTH - ID_W;
    localparam int LEN_LSB = ID_LSB - LEN_WIDTH;
    localparam int LAST_B  = LEN_LSB - 1;
    localparam logic [ID_W:0] NM = NUM_MOD[ID_W:0];

    state_t                  r_state, w_nstate;
    logic [ID_W-1:0]         r_id;
    logic [LEN_WIDTH-1:0]    r_cnt, r_iss_rem, w_rem_now, w_flen, w_hlen;
    logic                    r_last, r_err, r_pend, r_hwait, r_iss_last, r_iss_done;
    logic [1:0]              w_occ;
    logic [2:0]              w_fill;
    logic [PORT_WIDTH-1:0]   w_head;
    logic [ID_W-1:0]         w_hid;
    logic [NUM_MOD-1:0]      w_vld_vec;
    logic                    w_start, w_bpop, w_bad, w_vld, w_hs, w_flast, w_hlast;
    logic                    w_pop_hdr, w_can, w_last_now, w_hdr_take, w_fin_hdr;

    cfg_skid_buf #(.W(PORT_WIDTH)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_pend),
        .i_din  (fifo_out),
        .i_pop  (w_bpop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign w_start    = (r_state == S_IDLE) && start;
    assign w_hid      = w_head[PORT_WIDTH-1 -: ID_W];
    assign w_hlen     = w_head[ID_LSB-1 -: LEN_WIDTH];
    assign w_hlast    = w_head[LAST_B];
    assign w_flen     = fifo_out[ID_LSB-1 -: LEN_WIDTH];
    assign w_flast    = fifo_out[LAST_B];
    assign w_bad      = {1'b0, r_id} >= NM;
    assign w_vld      = (r_state == S_PAY) && (w_occ != 2'd0);
    assign w_vld_vec  = (w_vld && !w_bad) ? (NUM_MOD'(1) << r_id) : '0;
    assign w_hs       = w_vld && (w_bad || |(w_vld_vec & TOPCCU_CfgRdy));
    assign w_hdr_take = (r_state == S_HDR) && (w_occ != 2'd0);

    // Issue-side header tracking: a header in flight is parsed straight off fifo_out so popping
    // stops exactly after the LAST config's payload, never prefetching into the next config.
    assign w_rem_now  = r_hwait ? w_flen : r_iss_rem;
    assign w_last_now = r_hwait ? w_flast : r_iss_last;
    assign w_fin_hdr  = r_hwait && (w_flen == '0) && w_flast;
    assign w_pop_hdr  = (w_rem_now == '0);
    assign w_can      = !r_iss_done && !w_fin_hdr;
    assign w_fill     = {1'b0, w_occ} + {2'b0, r_pend} - {2'b0, w_bpop};
    assign fifo_pop   = ((r_state == S_HDR) || (r_state == S_PAY)) && !fifo_empty &&
                        (w_fill < 3'd2) && w_can;

    // next state and buffer consume
    always_comb begin
        w_nstate = r_state;
        w_bpop   = 1'b0;
        case (r_state)
            S_IDLE: w_nstate = start ? S_HDR : S_IDLE;
            S_HDR: if (w_hdr_take) begin
                w_bpop   = 1'b1;
                w_nstate = (w_hlen != '0) ? S_PAY : (w_hlast ? S_FIN : S_HDR);
            end
            S_PAY: if (w_hs) begin
                w_bpop   = 1'b1;
                w_nstate = (r_cnt == LEN_WIDTH'(1)) ? (r_last ? S_FIN : S_HDR) : S_PAY;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // state register, latched header fields, payload counter and sticky id error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            if (w_start) r_err <= 1'b0;
            else if (w_hdr_take && ({1'b0, w_hid} >= NM)) r_err <= 1'b1;
            if (w_hdr_take) begin
                r_id   <= w_hid;
                r_cnt  <= w_hlen;
                r_last <= w_hlast;
            end else if (w_hs) begin
                r_cnt <= r_cnt - LEN_WIDTH'(1);
            end
        end
    end

    // pop bookkeeping: pending read plus words still to be issued for the current header
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_hwait    <= 1'b0;
            r_iss_rem  <= '0;
            r_iss_last <= 1'b0;
            r_iss_done <= 1'b0;
        end else begin
            r_pend <= fifo_pop;
            if (w_start) begin
                r_hwait    <= 1'b0;
                r_iss_rem  <= '0;
                r_iss_last <= 1'b0;
                r_iss_done <= 1'b0;
            end else begin
                r_hwait    <= fifo_pop && w_pop_hdr;
                r_iss_last <= w_last_now;
                r_iss_rem  <= (fifo_pop && !w_pop_hdr) ? w_rem_now - LEN_WIDTH'(1) : w_rem_now;
                if (w_fin_hdr || (fifo_pop && !w_pop_hdr && (w_rem_now == LEN_WIDTH'(1)) && w_last_now))
                    r_iss_done <= 1'b1;
            end
        end
    end

`ifdef CCU_CFG_STALL_CNT_EN
    logic [31:0] r_stall;
    // saturating count of cycles an engine holds off a valid payload word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stall <= '0;
        else if (w_start) r_stall <= '0;
        else if (|(w_vld_vec & ~TOPCCU_CfgRdy) && (r_stall != '1)) r_stall <= r_stall + 32'd1;
    end
    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

    assign CCUTOP_CfgVld  = w_vld_vec;
    assign CCUTOP_CfgInfo = w_head;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FIN);
    assign err_id         = r_err;
endmodule

// File: tb/tb_ccu_cfg_dispatch.sv
// tb_ccu_cfg_dispatch: directed checks of header parsing, payload dispatch, bad ids, gaps and reset
module tb_ccu_cfg_dispatch;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [127:0] fifo_out;
    logic [7:0]   vld;
    logic [127:0] info;
    logic [7:0]   rdy = 8'hFF;
    logic         busy, done, err_id;
    logic [31:0]  stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mem [256];
    int  wr = 0;
    int  rd = 0;
    logic gap = 1'b0;

    int cyc = 0, ln = 0, nvld = 0, multi = 0, unstable = 0, stalls = 0;
    int pops = 0, uflow = 0, vlow = 0, last_hs = 0, done_cyc = 0;
    int lp [64];
    logic [127:0] ld [64];
    logic p_stall = 1'b0;
    logic [7:0] p_vld = '0;
    logic [127:0] p_info = '0;

    ccu_cfg_dispatch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .fifo_empty     (fifo_empty),
        .fifo_pop       (fifo_pop),
        .fifo_out       (fifo_out),
        .CCUTOP_CfgVld  (vld),
        .CCUTOP_CfgInfo (info),
        .TOPCCU_CfgRdy  (rdy),
        .busy           (busy),
        .done           (done),
        .err_id         (err_id),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = gap || (rd == wr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd       <= wr;
            fifo_out <= '0;
        end else if (fifo_pop) begin
            fifo_out <= mem[rd[7:0]];
            rd       <= rd + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            for (int i = 0; i < 8; i++)
                if (vld[i] && rdy[i] && ln < 64) begin
                    lp[ln] = i;
                    ld[ln] = info;
                    ln++;
                    last_hs = cyc;
                end
            if ($countones(vld) > 1) multi++;
            if (vld != 0) nvld++;
            if (busy && vld == 0) vlow++;
            if (p_stall && (vld !== p_vld || info !== p_info)) unstable++;
            p_stall = |(vld & ~rdy);
            p_vld   = vld;
            p_info  = info;
            if (p_stall) stalls++;
            if (fifo_pop) pops++;
            if (fifo_pop && fifo_empty) uflow++;
            if (done) done_cyc = cyc;
        end
    end

    function automatic logic [127:0] hdr(input int id, input int len, input bit last);
        logic [127:0] h;
        h = '0;
        h[127:124] = id[3:0];
        h[123:116] = len[7:0];
        h[115] = last;
        return h;
    endfunction

    function automatic logic [127:0] pw(input int k);
        logic [31:0] v;
        v = 32'hC0DE0000 + k[31:0];
        return {v, ~v, v ^ 32'h5A5A5A5A, v + 32'd7};
    endfunction

    task automatic push(input logic [127:0] w);
        mem[wr[7:0]] = w;
        wr = wr + 1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string tag, input int max, input bit tog, input int g0, input int g1);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                if (tog) rdy[2] = ~rdy[2];
                gap = (k >= g0) && (k < g1);
            end
        end
        gap = 1'b0;
        #1;
        chk(tag, seen, 1'b1);
    endtask

    task automatic check_log(input string tag, input int base, input int port, input int k0, input int n);
        for (int j = 0; j < n; j++) begin
            chk({tag, "_port"}, lp[base+j], port);
            chk({tag, "_data"}, ld[base+j], pw(k0 + j));
        end
    endtask

    initial begin
        int b_ln, b_pops, b_nvld, b_st, b_vlow;
        repeat (3) @(negedge clk);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_vld", vld, 0);
        chk("rst_info", info, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_id, 0);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;

        // two configs: port 2 gets 3 words, port 5 gets the final one
        push(hdr(2, 3, 0)); push(pw(1)); push(pw(2)); push(pw(3));
        push(hdr(5, 1, 1)); push(pw(4));
        b_ln = ln; b_pops = pops;
        do_start();
        run("t1_done", 40, 0, 0, 0);
        chk("t1_count", ln - b_ln, 4);
        check_log("t1a", b_ln, 2, 1, 3);
        check_log("t1b", b_ln + 3, 5, 4, 1);
        chk("t1_pops", pops - b_pops, 6);
        chk("t1_done_lat", done_cyc - last_hs, 1);
        chk("t1_err", err_id, 0);
        @(negedge clk);
        chk("t1_idle", busy, 0);

        // ready toggling on port 2: four stalls interleave with four handshakes
        push(hdr(2, 4, 1)); push(pw(11)); push(pw(12)); push(pw(13)); push(pw(14));
        b_ln = ln; b_st = stalls;
        do_start();
        run("t2_done", 40, 1, 0, 0);
        rdy = 8'hFF;
        chk("t2_count", ln - b_ln, 4);
        check_log("t2", b_ln, 2, 11, 4);
        chk("t2_stalls", stalls - b_st, 4);
        chk("t2_stable", unstable, 0);
`ifdef CCU_CFG_STALL_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 4);
`else
        chk("t2_stall_cnt", stall_cnt, 0);
`endif

        // bad id 9 drains two words without ready, then port 0 gets one word
        push(hdr(9, 2, 0)); push(pw(21)); push(pw(22));
        push(hdr(0, 1, 1)); push(pw(23));
        rdy = 8'h01;
        b_ln = ln; b_nvld = nvld; b_pops = pops;
        do_start();
        run("t3_done", 40, 0, 0, 0);
        chk("t3_err", err_id, 1);
        chk("t3_count", ln - b_ln, 1);
        check_log("t3", b_ln, 0, 23, 1);
        chk("t3_nvld", nvld - b_nvld, 1);
        chk("t3_pops", pops - b_pops, 5);
        rdy = 8'hFF;

        // zero-length headers; the next config's header must stay in the FIFO
        push(hdr(1, 0, 0)); push(hdr(3, 0, 1)); push(hdr(4, 8, 1));
        b_ln = ln; b_nvld = nvld; b_pops = pops;
        do_start();
        run("t4_done", 40, 0, 0, 0);
        chk("t4_err_clr", err_id, 0);
        chk("t4_count", ln - b_ln, 0);
        chk("t4_nvld", nvld - b_nvld, 0);
        chk("t4_pops", pops - b_pops, 2);
        chk("t4_left", fifo_empty, 0);

        // five-cycle FIFO gap mid-payload on port 4
        for (int k = 31; k <= 38; k++) push(pw(k));
        b_ln = ln; b_vlow = vlow;
        do_start();
        run("t5_done", 60, 0, 2, 7);
        chk("t5_count", ln - b_ln, 8);
        check_log("t5", b_ln, 4, 31, 8);
        chk("t5_vlow", vlow - b_vlow, 9);
        chk("t5_uflow", uflow, 0);
        chk("t5_multi", multi, 0);

        // reset in PAY with a read in flight, then a clean dispatch
        push(hdr(6, 5, 1));
        for (int k = 41; k <= 45; k++) push(pw(k));
        rdy = 8'h00;
        do_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_pay", vld, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("t6_pop", fifo_pop, 0);
        chk("t6_vld", vld, 0);
        chk("t6_info", info, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_stall", stall_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy = 8'hFF;
        push(hdr(7, 2, 1)); push(pw(51)); push(pw(52));
        b_ln = ln;
        do_start();
        run("t6b_done", 40, 0, 0, 0);
        chk("t6b_count", ln - b_ln, 2);
        check_log("t6b", b_ln, 7, 51, 2);
        chk("t6b_stall", stall_cnt, 0);
        chk("t6b_empty", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
